// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and scoreboard types for the pipeline hazard/forwarding controller.
// Helper reg_hit() is the single definition of "slot produces register r".
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL_LOAD = 2'd1,
        ST_STALL_JR   = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_e;

    // EX slot keeps source fields for forwarding; later slots only need the producer side.
    typedef struct packed {
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs;
        logic [4:0] rt;
    } ex_slot_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       reg_write;
    } ret_slot_t;

    function automatic logic reg_hit(input logic vld, input logic wr,
                                     input logic [4:0] dest, input logic [4:0] r);
        return vld && wr && (dest != REG_ZERO) && (dest == r);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding mux select for one ALU operand; the MEM producer wins over WB
// because it carries the newer value.
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] dest_mem,
    input  logic       wr_mem,
    input  logic       vld_mem,
    input  logic [4:0] dest_wb,
    input  logic       wr_wb,
    input  logic       vld_wb,
    input  logic [4:0] src,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (reg_hit(vld_mem, wr_mem, dest_mem, src)) begin
            sel = FWD_EXMEM;
        end else if (reg_hit(vld_wb, wr_wb, dest_wb, src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: EX/MEM/WB scoreboard,
// forwarding selects, stall/flush/PC-select control and saturating debug counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             ex_branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ctrl_pass,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             branch_sel,
    output logic             jump_sel,
    output logic             jr_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Scoreboard: _p0 = EX, _p1 = MEM, _p2 = WB
    ex_slot_t  ex_p0;
    ret_slot_t ret_p1, ret_p2;
    logic      vld_p0, vld_p1, vld_p2;

    hz_state_e state_q, state_d;
    logic      bubble;
    logic      br_take, load_use, jr_haz;
    logic [1:0] sel_a, sel_b;

    fwd_select u_fwd_a (
        .dest_mem (ret_p1.dest),
        .wr_mem   (ret_p1.reg_write),
        .vld_mem  (vld_p1),
        .dest_wb  (ret_p2.dest),
        .wr_wb    (ret_p2.reg_write),
        .vld_wb   (vld_p2),
        .src      (ex_p0.rs),
        .sel      (sel_a)
    );

    fwd_select u_fwd_b (
        .dest_mem (ret_p1.dest),
        .wr_mem   (ret_p1.reg_write),
        .vld_mem  (vld_p1),
        .dest_wb  (ret_p2.dest),
        .wr_wb    (ret_p2.reg_write),
        .vld_wb   (vld_p2),
        .src      (ex_p0.rt),
        .sel      (sel_b)
    );

    assign fwd_a = vld_p0 ? sel_a : FWD_REG;
    assign fwd_b = vld_p0 ? sel_b : FWD_REG;

    assign br_take  = vld_p0 && ex_branch_taken;
    assign load_use = id_valid && vld_p0 && ex_p0.mem_read && (ex_p0.dest != REG_ZERO) &&
                      ((id_uses_rs && (ex_p0.dest == id_rs)) ||
                       (id_uses_rt && (ex_p0.dest == id_rt)));
    // A WB producer is safe: the register file writes through to the read port.
    assign jr_haz   = id_valid && id_jr &&
                      (reg_hit(vld_p0, ex_p0.reg_write, ex_p0.dest, id_rs) ||
                       reg_hit(vld_p1, ret_p1.reg_write, ret_p1.dest, id_rs));

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ctrl_pass  = 1'b1;
        ifid_flush = 1'b0;
        branch_sel = 1'b0;
        jump_sel   = 1'b0;
        jr_sel     = 1'b0;
        bubble     = 1'b0;
        state_d    = ST_RUN;
        if (br_take) begin
            // ID holds a wrong-path instruction, so its hazards are irrelevant.
            branch_sel = 1'b1;
            ifid_flush = 1'b1;
            ctrl_pass  = 1'b0;
            bubble     = 1'b1;
            state_d    = ST_FLUSH;
        end else if (load_use || jr_haz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_pass  = 1'b0;
            bubble     = 1'b1;
            state_d    = jr_haz ? ST_STALL_JR : ST_STALL_LOAD;
        end else if (id_valid && id_jump) begin
            jump_sel   = 1'b1;
            ifid_flush = 1'b1;
            state_d    = ST_FLUSH;
        end else if (id_valid && id_jr) begin
            jr_sel     = 1'b1;
            ifid_flush = 1'b1;
            state_d    = ST_FLUSH;
        end
    end

    assign state = state_q;

    // Stage boundary ID -> EX -> MEM -> WB (data fields)
    always_ff @(posedge clk) begin
        ex_p0  <= '{dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read,
                    rs: id_rs, rt: id_rt};
        ret_p1 <= '{dest: ex_p0.dest, reg_write: ex_p0.reg_write};
        ret_p2 <= ret_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            state_q     <= ST_RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            vld_p0  <= id_valid && !bubble;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            state_q <= state_d;
            if (!pc_write) begin
                stall_count <= sat_inc(stall_count);
            end
            if (ifid_flush) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, saturation and reset-abort
// sequences, then random ID traffic against an instruction-history reference model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ctl packing: {pc_write, ifid_write, ctrl_pass, ifid_flush, branch_sel, jump_sel, jr_sel}
    localparam logic [6:0] C_RUN   = 7'b1110000;
    localparam logic [6:0] C_STALL = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1101100;
    localparam logic [6:0] C_JMP   = 7'b1111010;
    localparam logic [6:0] C_JR    = 7'b1111001;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_jump, id_jr;
    logic ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;
    logic [1:0] fwd_a, fwd_b, state;
    logic ctrl_pass, pc_write, ifid_write, ifid_flush, branch_sel, jump_sel, jr_sel;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_jump(id_jump), .id_jr(id_jr), .ex_branch_taken(ex_branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_pass(ctrl_pass), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .branch_sel(branch_sel),
        .jump_sel(jump_sel), .jr_sel(jr_sel), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dest;
        logic       rw, mr, j, jr;
    } instr_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic [6:0] ctl;
        logic [1:0] st;
        int         sc, fc;
    } exp_t;

    typedef struct {
        instr_t in;
        logic   br;
        exp_t   e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int want_sc = -1;

    // Reference model: the last three instructions that entered EX, newest first.
    instr_t pipe [3];
    int     m_state, m_sc, m_fc;

    function automatic instr_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                  logic [4:0] dest, logic rw, logic mr, logic j, logic jr);
        instr_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.dest = dest; i.rw = rw; i.mr = mr; i.j = j; i.jr = jr;
        return i;
    endfunction

    function automatic exp_t ex(logic [1:0] fa, logic [1:0] fb, logic [6:0] ctl,
                                logic [1:0] st, int sc, int fc);
        exp_t e;
        e.fa = fa; e.fb = fb; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    function automatic bit writes(instr_t p, logic [4:0] r);
        return p.valid && p.rw && (p.dest != 5'd0) && (p.dest == r);
    endfunction

    function automatic int fwd_of(logic [4:0] src);
        for (int k = 1; k <= 2; k++) begin
            if (writes(pipe[k], src)) return k;
        end
        return 0;
    endfunction

    function automatic int sat(int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic exp_t model_eval(instr_t i, logic br, output bit bub, output int nst);
        exp_t e;
        bit taken, lu, jh;
        instr_t x;
        x = pipe[0];
        e.fa = x.valid ? 2'(fwd_of(x.rs)) : 2'd0;
        e.fb = x.valid ? 2'(fwd_of(x.rt)) : 2'd0;
        taken = x.valid && br;
        lu = i.valid && x.valid && x.mr && (x.dest != 5'd0) &&
             ((i.urs && x.dest == i.rs) || (i.urt && x.dest == i.rt));
        jh = i.valid && i.jr && (writes(pipe[0], i.rs) || writes(pipe[1], i.rs));
        if (taken) begin
            e.ctl = C_BR; bub = 1; nst = 3;
        end else if (lu || jh) begin
            e.ctl = C_STALL; bub = 1; nst = jh ? 2 : 1;
        end else if (i.valid && i.j) begin
            e.ctl = C_JMP; bub = 0; nst = 3;
        end else if (i.valid && i.jr) begin
            e.ctl = C_JR; bub = 0; nst = 3;
        end else begin
            e.ctl = C_RUN; bub = 0; nst = 0;
        end
        e.st = 2'(m_state);
        e.sc = m_sc;
        e.fc = m_fc;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_state = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_advance(instr_t i, exp_t e, bit bub, int nst);
        if (!e.ctl[6]) m_sc = sat(m_sc);
        if (e.ctl[3])  m_fc = sat(m_fc);
        m_state = nst;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = i;
        if (bub) pipe[0].valid = 1'b0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cmp_all(string p, exp_t e);
        chk({p, "_fwd_a"}, 32'(fwd_a), 32'(e.fa));
        chk({p, "_fwd_b"}, 32'(fwd_b), 32'(e.fb));
        chk({p, "_ctl"}, 32'({pc_write, ifid_write, ctrl_pass, ifid_flush,
                              branch_sel, jump_sel, jr_sel}), 32'(e.ctl));
        chk({p, "_state"}, 32'(state), 32'(e.st));
        chk({p, "_stall_count"}, 32'(stall_count), 32'(e.sc));
        chk({p, "_flush_count"}, 32'(flush_count), 32'(e.fc));
    endtask

    task automatic drive(instr_t i, logic br);
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
        id_dest = i.dest; id_reg_write = i.rw; id_mem_read = i.mr; id_jump = i.j; id_jr = i.jr;
        ex_branch_taken = br;
    endtask

    task automatic cycle(instr_t i, logic br, logic rst, bit use_tbl, exp_t t);
        exp_t e;
        bit bub;
        int nst;
        drive(i, br);
        reset = rst;
        @(negedge clk);
        e = model_eval(i, br, bub, nst);
        cmp_all("mdl", e);
        if (use_tbl) cmp_all("tbl", t);
        if (want_sc >= 0) begin
            chk("stall_sat", 32'(stall_count), 32'(want_sc));
            want_sc = -1;
        end
        chk("sel_onehot", 32'($countones({branch_sel, jump_sel, jr_sel}) <= 1), 32'd1);
        @(posedge clk);
        if (rst) model_reset();
        else model_advance(i, e, bub, nst);
        #1;
    endtask

    function automatic logic [4:0] rreg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t IDLE, ADD3, SUB4, OR8, ADD0, SUB4Z, LW5, ADD6, LW31, JR31, JAL, ri;
        exp_t   none;
        vec_t   tbl [$];

        IDLE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ADD3  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        SUB4  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        OR8   = mk(1, 9, 10, 1, 1, 8, 1, 0, 0, 0);
        ADD0  = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
        SUB4Z = mk(1, 0, 5, 1, 1, 4, 1, 0, 0, 0);
        LW5   = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        ADD6  = mk(1, 7, 5, 1, 1, 6, 1, 0, 0, 0);
        LW31  = mk(1, 1, 0, 1, 0, 31, 1, 1, 0, 0);
        JR31  = mk(1, 31, 0, 1, 0, 0, 0, 0, 0, 1);
        JAL   = mk(1, 0, 0, 0, 0, 31, 1, 0, 1, 0);
        none  = ex(0, 0, C_RUN, 0, 0, 0);

        tbl.push_back('{IDLE,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{ADD3,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{SUB4,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{IDLE,  0, ex(1, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{ADD3,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{OR8,   0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{SUB4,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{IDLE,  0, ex(2, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{ADD0,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{SUB4Z, 0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{IDLE,  0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{LW5,   0, ex(0, 0, C_RUN,   0, 0, 0)});
        tbl.push_back('{ADD6,  0, ex(0, 0, C_STALL, 0, 0, 0)});
        tbl.push_back('{ADD6,  0, ex(0, 0, C_RUN,   1, 1, 0)});
        tbl.push_back('{IDLE,  0, ex(0, 2, C_RUN,   0, 1, 0)});
        tbl.push_back('{LW31,  0, ex(0, 0, C_RUN,   0, 1, 0)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_STALL, 0, 1, 0)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_STALL, 2, 2, 0)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_JR,    2, 3, 0)});
        tbl.push_back('{IDLE,  0, ex(0, 0, C_RUN,   3, 3, 1)});
        tbl.push_back('{LW5,   0, ex(0, 0, C_RUN,   0, 3, 1)});
        tbl.push_back('{ADD6,  1, ex(0, 0, C_BR,    0, 3, 1)});
        tbl.push_back('{IDLE,  0, ex(0, 0, C_RUN,   3, 3, 2)});
        tbl.push_back('{JAL,   0, ex(0, 0, C_JMP,   0, 3, 2)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_STALL, 3, 3, 3)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_STALL, 2, 4, 3)});
        tbl.push_back('{JR31,  0, ex(0, 0, C_JR,    2, 5, 3)});
        tbl.push_back('{IDLE,  0, ex(0, 0, C_RUN,   3, 5, 4)});

        drive(IDLE, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].in, tbl[k].br, 1'b0, 1'b1, tbl[k].e);
        end

        // Twelve more load-use stalls push stall_count from 5 past its ceiling.
        for (int n = 0; n < 12; n++) begin
            cycle(LW5, 0, 1'b0, 1'b0, none);
            cycle(ADD6, 0, 1'b0, 1'b0, none);
            cycle(ADD6, 0, 1'b0, 1'b0, none);
        end
        want_sc = CNT_MAX;
        cycle(IDLE, 0, 1'b0, 1'b0, none);

        // Reset lands while the jr is held in STALL_JR.
        cycle(LW31, 0, 1'b0, 1'b0, none);
        cycle(JR31, 0, 1'b0, 1'b1, ex(0, 0, C_STALL, 0, CNT_MAX, 4));
        cycle(JR31, 0, 1'b1, 1'b1, ex(0, 0, C_STALL, 2, CNT_MAX, 4));
        cycle(IDLE, 0, 1'b0, 1'b1, ex(0, 0, C_RUN, 0, 0, 0));

        for (int n = 0; n < 3000; n++) begin
            ri = mk($urandom_range(0, 99) < 85, rreg(), rreg(), 1'($urandom), 1'($urandom),
                    rreg(), 1'($urandom), $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
            cycle(ri, $urandom_range(0, 99) < 15, $urandom_range(0, 199) == 0, 1'b0, none);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard/forwarding controller for the 5-stage MIPS pipeline. It tracks the destination registers of in-flight instructions in an internal EX/MEM/WB scoreboard. From that it drives the control lines of the forwarding muxes, the hazard-stall mux and the three PC-select muxes (branch/jump/jr), plus IF/ID write/flush and PC write. It also keeps saturating stall/flush event counters for debug.

Parameters:
CNT_W, 16, width of stall_count and flush_count (saturating)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  rs field of ID instruction
id_rt  in  5  rt field of ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  5  write register after RegDst selection (31 for jal)
id_reg_write  in  1  RegWrite of ID instruction
id_mem_read  in  1  MemRead (load) of ID instruction
id_jump  in  1  j/jal decoded in ID
id_jr  in  1  jr decoded in ID
ex_branch_taken  in  1  branch AND-gate result for the EX instruction
fwd_a  out  2  0=reg rs, 1=EX/MEM result, 2=MEM/WB result
fwd_b  out  2  same encoding, for rt
ctrl_pass  out  1  hazard-stall mux select; 0 inserts bubble (zero controls), 1 passes control unit
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  zero IF/ID on next edge
branch_sel  out  1  first PC mux: 1 selects BTA
jump_sel  out  1  second PC mux: 1 selects jump address
jr_sel  out  1  third PC mux: 1 selects rs value
state  out  2  registered: 0 RUN, 1 STALL_LOAD, 2 STALL_JR, 3 FLUSH
stall_count  out  CNT_W  cycles with pc_write=0
flush_count  out  CNT_W  cycles with ifid_flush=1

Behaviour:
- Scoreboard: slots EX, MEM, WB, each holding {valid, dest, reg_write, mem_read, rs, rt}.
- Slot update on every edge: MEM<=EX and WB<=MEM. EX<=ID fields with valid=id_valid, unless a bubble is inserted (stall or branch flush), in which case EX.valid<=0.
- Match(slot, r) = slot.valid & slot.reg_write & slot.dest!=0 & slot.dest==r. Register $0 never matches.
- Forwarding (combinational from the slots):
  - fwd_a=1 if Match(MEM, EX.rs); else 2 if Match(WB, EX.rs); else 0. MEM has priority (newest value).
  - fwd_b is the same using EX.rt.
  - Both are 0 when EX.valid=0.
- Load-use hazard: EX.valid & EX.mem_read & EX.dest!=0 & ((id_uses_rs & EX.dest==id_rs) | (id_uses_rt & EX.dest==id_rt)), qualified by id_valid. Lasts exactly 1 cycle.
- JR hazard: id_valid & id_jr & (Match(EX, id_rs) | Match(MEM, id_rs)). The register file is write-through, so a producer in WB is safe. Worst case (load immediately before jr) is 2 stall cycles.
- Priority, highest first:
  1. Branch taken: EX.valid & ex_branch_taken gives branch_sel=1, ifid_flush=1, bubble into EX (ctrl_pass=0), pc_write=1. ID hazards are ignored because ID is wrong-path. state->FLUSH.
  2. Stall (load-use or JR hazard): pc_write=0, ifid_write=0, ctrl_pass=0, all PC selects 0. state->STALL_LOAD or STALL_JR; JR takes precedence for the state code.
  3. Jump: id_valid & id_jump gives jump_sel=1, ifid_flush=1. The jump instruction itself proceeds to EX, so jal writes $31. state->FLUSH.
  4. jr, no hazard: jr_sel=1, ifid_flush=1. state->FLUSH.
  5. Otherwise: pc_write=1, ifid_write=1, ctrl_pass=1, selects 0, flush 0. state->RUN.
- The select outputs are one-hot or all zero; at most one of branch_sel/jump_sel/jr_sel is ever 1.
- Counters: increment at the edge following a qualifying cycle and saturate at all-ones. They do not wrap.
- Reset (synchronous, active-high; takes priority over everything):
  - all slots valid=0, state=RUN, counters=0;
  - consequently fwd_a=fwd_b=0 and pc_write=ifid_write=ctrl_pass=1 from the first cycle after reset, with branch_sel/jump_sel/jr_sel/ifid_flush=0 given idle ID inputs.
  - Reset asserted mid-stall aborts the stall; no counter increment occurs on the reset edge.

Decomposition:
- Shared include pipe_defs.vh:
  - FWD_REG/FWD_EXMEM/FWD_MEMWB = 0/1/2;
  - ST_RUN/ST_STALL_LOAD/ST_STALL_JR/ST_FLUSH;
  - REG_ZERO=0, REG_RA=31.
- One sub-module fwd_select(dest_mem, wr_mem, vld_mem, dest_wb, wr_wb, vld_wb, src) -> 2-bit select, instantiated twice (A and B).

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> fwd_a=1 while sub in EX. With one unrelated instruction between them -> fwd_a=2. add $0 producer -> fwd_a=0.
- lw $5,0($1) then add $6,$7,$5 -> exactly 1 cycle of pc_write=0, ifid_write=0, ctrl_pass=0, state=STALL_LOAD. Next cycle with add in EX: fwd_b=2. stall_count=1.
- lw $31 then jr $31 -> 2 stall cycles (state=STALL_JR), then jr_sel=1 and ifid_flush=1 for one cycle. stall_count=2, flush_count=1.
- ex_branch_taken=1 with EX valid while ID presents a load-use hazard -> branch_sel=1, ifid_flush=1, ctrl_pass=0, pc_write=1, no stall. flush_count increments by 1.
- jal in ID (id_dest=31) -> jump_sel=1, ifid_flush=1. Next cycle EX.dest=31, and a following jr $31 stalls 2 cycles.
- Force stall_count to all-ones via repeated stalls (CNT_W=4) -> holds at 15. Assert reset during a STALL_JR -> next cycle state=RUN, pc_write=1, counters=0, fwd_a=fwd_b=0.
